// File: rtl/reg_file.sv
// Eight-entry, 16-bit register file: two combinational read ports, one write every clock.
// Optional write-first forwarding on the read ports when REGFILE_BYPASS_EN is defined.
module reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] result,
    input  logic [2:0]  result_w,
    input  logic [2:0]  rd_addr,
    input  logic [2:0]  rs_addr,
    output logic [15:0] rd_out,
    output logic [15:0] rs_out
);

    // Kept under this exact name so benches can inspect it hierarchically.
    logic [15:0] reg_file [0:7];

    // Reset beats the write; there is no write enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                reg_file[i] <= 16'h0000;
            end
        end else begin
            reg_file[result_w] <= result;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic rd_fwd;
    logic rs_fwd;

    // Forwarding is held off during reset so the outputs show the cleared array.
    assign rd_fwd = !rst && (rd_addr == result_w);
    assign rs_fwd = !rst && (rs_addr == result_w);

    always_comb begin
        rd_out = rd_fwd ? result : reg_file[rd_addr];
        rs_out = rs_fwd ? result : reg_file[rs_addr];
    end
`else
    always_comb begin
        rd_out = reg_file[rd_addr];
        rs_out = reg_file[rs_addr];
    end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed cases plus randomized traffic against an array model.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic [15:0] result;
    logic [2:0]  result_w;
    logic [2:0]  rd_addr;
    logic [2:0]  rs_addr;
    logic [15:0] rd_out;
    logic [15:0] rs_out;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    logic [15:0] model [8];

    reg_file dut (
        .clk      (clk),
        .rst      (rst),
        .result   (result),
        .result_w (result_w),
        .rd_addr  (rd_addr),
        .rs_addr  (rs_addr),
        .rd_out   (rd_out),
        .rs_out   (rs_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // What a read port should show for an address given the current inputs and stored state.
    function automatic logic [15:0] exp_read(input logic [2:0] addr);
`ifdef REGFILE_BYPASS_EN
        if (!rst && addr == result_w) return result;
`endif
        return model[addr];
    endfunction

    task automatic drive(input logic r, input logic [15:0] d, input logic [2:0] w,
                         input logic [2:0] a, input logic [2:0] b);
        rst      = r;
        result   = d;
        result_w = w;
        rd_addr  = a;
        rs_addr  = b;
    endtask

    // One clock: check reads before the edge, apply the edge to the model, check after it.
    task automatic cycle(input bit check_pre);
        #1;
        if (check_pre) begin
            check("rd_pre", rd_out, exp_read(rd_addr));
            check("rs_pre", rs_out, exp_read(rs_addr));
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        end else begin
            model[result_w] = result;
        end
        #1;
        check("rd_post", rd_out, exp_read(rd_addr));
        check("rs_post", rs_out, exp_read(rs_addr));
        for (int i = 0; i < 8; i++) check($sformatf("entry%0d", i), dut.reg_file[i], model[i]);
        txn++;
        $display("txn %0d rst=%0b w=%0d data=%h rd[%0d]=%h rs[%0d]=%h",
                 txn, rst, result_w, result, rd_addr, rd_out, rs_addr, rs_out);
    endtask

    task automatic sweep_reads(input string tag);
        for (int a = 0; a < 8; a++) begin
            rd_addr = a[2:0];
            rs_addr = 3'(7 - a);
            #1;
            check({tag, "_rd"}, rd_out, exp_read(rd_addr));
            check({tag, "_rs"}, rs_out, exp_read(rs_addr));
        end
    endtask

    initial begin
        drive(1'b1, 16'hFFFF, 3'd5, 3'd0, 3'd7);
        // Initial reset: contents undefined before the edge, so no pre-edge check.
        cycle(1'b0);
        sweep_reads("reset");
        check("reset_rd_lit", rd_out, 16'h0000);

        // Preload reg[i] = i, then the first test-plan write.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 16'(i), 3'(i), 3'(i), 3'(i));
            cycle(1'b1);
        end
        drive(1'b0, 16'd3, 3'd1, 3'd1, 3'd3);
        cycle(1'b1);
        check("t1_rd", rd_out, 16'd3);
        check("t1_rs", rs_out, 16'd3);
        check("t1_reg1", dut.reg_file[1], 16'd3);

        // Mid-operation reset with a write presented on the same edge.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 16'h0100 + 16'(i), 3'(i), 3'(i), 3'(i));
            cycle(1'b1);
        end
        drive(1'b1, 16'hFFFF, 3'd5, 3'd5, 3'd5);
        cycle(1'b1);
        check("t2_reg5", dut.reg_file[5], 16'h0000);
        sweep_reads("t2");

        // Extreme entries on consecutive edges.
        drive(1'b0, 16'hA5A5, 3'd7, 3'd7, 3'd0);
        cycle(1'b1);
        drive(1'b0, 16'h5A5A, 3'd0, 3'd7, 3'd0);
        cycle(1'b1);
        check("t3_rd7", rd_out, 16'hA5A5);
        check("t3_rs0", rs_out, 16'h5A5A);

        // Both ports on the same register.
        drive(1'b0, 16'h1234, 3'd4, 3'd4, 3'd4);
        cycle(1'b1);
        check("t4_rd", rd_out, 16'h1234);
        check("t4_rs", rs_out, 16'h1234);

        // Same-cycle read/write of one address.
        drive(1'b0, 16'h0002, 3'd2, 3'd2, 3'd2);
        cycle(1'b1);
        drive(1'b0, 16'hBEEF, 3'd2, 3'd2, 3'd5);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("t5_pre", rd_out, 16'hBEEF);
`else
        check("t5_pre", rd_out, 16'h0002);
`endif
        cycle(1'b1);
        check("t5_post", rd_out, 16'hBEEF);

        // Data sweep on a fixed address.
        begin
            logic [15:0] vals [3];
            vals[0] = 16'h0000;
            vals[1] = 16'h8000;
            vals[2] = 16'hFFFF;
            for (int k = 0; k < 3; k++) begin
                drive(1'b0, vals[k], 3'd6, 3'd6, 3'd1);
                cycle(1'b1);
                check("t6_reg6", dut.reg_file[6], vals[k]);
            end
        end

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 150; n++) begin
            drive(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, 16'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            cycle(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
